// File: rtl/rcosc_div_pkg.sv
// Shared constants and types for the multi-channel RC-oscillator divider.
package rcosc_div_pkg;

  localparam int PKG_DIV_W       = 16;
  localparam int PKG_DEFAULT_DIV = 160;

  typedef logic [PKG_DIV_W-1:0] div_t;

  typedef enum logic [1:0] {
    SLOT_RST  = 2'd0,
    SLOT_IDLE = 2'd1,
    SLOT_PEND = 2'd2
  } slot_state_e;

  // Channel-index width; never zero so a single-channel build still has a CFG_CH bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rcosc_div_chan.sv
// One divider channel: wrap counter, live ratio, registered CE strobe and divided square wave.
module rcosc_div_chan
  import rcosc_div_pkg::*;
#(
  parameter int DIV_W       = PKG_DIV_W,
  parameter int DEFAULT_DIV = PKG_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             apply_req_i,
  input  logic [DIV_W-1:0] apply_div_i,
  output logic             applied_o,
  output logic             ce_o,
  output logic             div_out_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             ce_q, ce_d;
  logic             div_out_q, div_out_d;
  logic             run, tc, apply;

  always_comb begin
    run = en_i & en_q;
    tc  = run & (count_q == (div_q - DIV_W'(1)));
    // New ratio only lands on a wrap, while idle, or on a realign, so no period is cut short.
    apply = apply_req_i & (tc | ~run | sync_i);
    div_d = apply ? apply_div_i : div_q;
    en_d  = en_i;
    if (!run || tc || sync_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
    ce_d      = tc;
    div_out_d = run & ((div_d == DIV_W'(1)) | (count_d < (div_d >> 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      en_q      <= 1'b0;
      ce_q      <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      en_q      <= en_d;
      ce_q      <= ce_d;
      div_out_q <= div_out_d;
    end
  end

  assign applied_o = apply;
  assign ce_o      = ce_q;
  assign div_out_o = div_out_q;

endmodule

// File: rtl/rcosc_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with a single pending ratio-change slot.
//
//  state     | meaning
//  SLOT_RST  | just out of reset, config port not yet offered
//  SLOT_IDLE | slot empty, CFG_READY high
//  SLOT_PEND | ratio held for one channel, waiting for that channel to apply it
module rcosc_div_gen
  import rcosc_div_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = PKG_DIV_W,
  parameter int  DEFAULT_DIV = PKG_DEFAULT_DIV,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  output logic              CFG_ERR,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              SYNC_IN,
  output logic [NUM_CH-1:0] CE_OUT,
  output logic [NUM_CH-1:0] DIV_OUT
);

  localparam logic [31:0] NUM_CH_U = NUM_CH;

  slot_state_e       state_q;
  logic              ready_q, err_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [DIV_W-1:0]  pend_div_q;
  logic [NUM_CH-1:0] apply_req, applied;
  logic              cfg_legal, xfer, any_applied;

  always_comb begin
    cfg_legal   = (CFG_DIV != '0) && (32'(CFG_CH) < NUM_CH_U);
    xfer        = CFG_VALID & ready_q;
    any_applied = |applied;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= SLOT_RST;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SLOT_RST: begin
          state_q <= SLOT_IDLE;
          ready_q <= 1'b1;
        end
        SLOT_IDLE: begin
          if (xfer) begin
            if (cfg_legal) begin
              pend_ch_q  <= CFG_CH;
              pend_div_q <= CFG_DIV;
              state_q    <= SLOT_PEND;
              ready_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SLOT_PEND: begin
          if (any_applied) begin
            state_q <= SLOT_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= SLOT_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign apply_req[gi] = (state_q == SLOT_PEND) && (pend_ch_q == CH_W'(gi));

    rcosc_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk        (CLK),
      .rst        (RESET),
      .en_i       (CH_EN[gi]),
      .sync_i     (SYNC_IN),
      .apply_req_i(apply_req[gi]),
      .apply_div_i(pend_div_q),
      .applied_o  (applied[gi]),
      .ce_o       (CE_OUT[gi]),
      .div_out_o  (DIV_OUT[gi])
    );
  end

  assign CFG_READY = ready_q;
  assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_rcosc_div_gen.sv
// Directed bench for rcosc_div_gen: default period, ratio change, errors, enable, sync, reset.
module tb_rcosc_div_gen;

  localparam int NCH = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_err;
  logic [NCH-1:0] ch_en;
  logic        sync_in;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] div_out;

  int n_tests = 0;
  int n_fail  = 0;

  rcosc_div_gen #(.NUM_CH(NCH), .DIV_W(16), .DEFAULT_DIV(160)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready),
    .CFG_CH   (cfg_ch),
    .CFG_DIV  (cfg_div),
    .CFG_ERR  (cfg_err),
    .CH_EN    (ch_en),
    .SYNC_IN  (sync_in),
    .CE_OUT   (ce_out),
    .DIV_OUT  (div_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_send(input int ch, input int dv);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = 16'(dv);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    for (int k = 0; k < budget && !cfg_ready; k++) tick();
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: CFG_READY=%b after %0d cycles, required 1", name, cfg_ready, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0; sync_in = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (ce_out !== 5'h00) begin n_fail++; $display("FAIL reset_ce: got %h need 00", ce_out); end
    n_tests++;
    if (div_out !== 5'h00) begin n_fail++; $display("FAIL reset_div: got %h need 00", div_out); end
    n_tests++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg: ready=%b err=%b need 0/0", cfg_ready, cfg_err);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b need 1", cfg_ready); end
  endtask

  task automatic test_default_period();
    int strobes[NCH];
    int first[NCH];
    int hi0;
    for (int i = 0; i < NCH; i++) begin strobes[i] = 0; first[i] = 0; end
    hi0 = 0;
    ch_en = 5'h1F;
    for (int k = 1; k <= 481; k++) begin
      tick();
      for (int i = 0; i < NCH; i++) begin
        if (ce_out[i]) begin
          strobes[i]++;
          if (first[i] == 0) first[i] = k;
        end
      end
      if (k >= 161 && k <= 320 && div_out[0]) hi0++;
    end
    for (int i = 0; i < NCH; i++) begin
      n_tests++;
      if (strobes[i] != 3 || first[i] != 161) begin
        n_fail++;
        $display("FAIL default_ce ch%0d: strobes=%0d first=%0d need 3/161", i, strobes[i], first[i]);
      end
    end
    n_tests++;
    if (hi0 != 80) begin n_fail++; $display("FAIL default_div_high: got %0d need 80", hi0); end
  endtask

  task automatic test_ratio_change();
    int strobes, first, last;
    logic rdy_early, rdy_late, rdy_apply;
    strobes = 0; first = -1; last = -1;
    rdy_early = 1'b1; rdy_late = 1'b1; rdy_apply = 1'b0;
    repeat (50) tick();
    cfg_send(0, 10);
    for (int j = 0; j <= 129; j++) begin
      if (j > 0) tick();
      if (j == 0) rdy_early = cfg_ready;
      if (j == 108) rdy_late = cfg_ready;
      if (j == 109) rdy_apply = cfg_ready;
      if (ce_out[0]) begin
        strobes++;
        if (first < 0) first = j;
        last = j;
      end
    end
    n_tests++;
    if (rdy_early !== 1'b0 || rdy_late !== 1'b0) begin
      n_fail++; $display("FAIL ratio_ready_low: got %b/%b need 0/0", rdy_early, rdy_late);
    end
    n_tests++;
    if (rdy_apply !== 1'b1) begin n_fail++; $display("FAIL ratio_ready_back: got %b need 1", rdy_apply); end
    n_tests++;
    if (strobes != 3 || first != 109 || last != 129) begin
      n_fail++;
      $display("FAIL ratio_strobes: count=%0d first=%0d last=%0d need 3/109/129", strobes, first, last);
    end
  endtask

  task automatic test_cfg_err();
    int strobes;
    cfg_send(0, 0);
    n_tests++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_div0: err=%b ready=%b need 1/1", cfg_err, cfg_ready);
    end
    tick();
    n_tests++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b need 0", cfg_err); end
    cfg_send(NCH, 20);
    n_tests++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_bad_ch: err=%b ready=%b need 1/1", cfg_err, cfg_ready);
    end
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ce_out[0]) strobes++;
    end
    n_tests++;
    if (strobes != 3 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_untouched: ch0 strobes=%0d ready=%b need 3/1", strobes, cfg_ready);
    end
  endtask

  task automatic test_enable();
    int strobes, first, hi;
    int ok;
    ch_en = 5'b11101;
    tick();
    cfg_send(1, 7);
    wait_ready("enable_cfg_apply", 4);
    ch_en = 5'h1F;
    strobes = 0; first = 0; hi = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (ce_out[1]) begin strobes++; if (first == 0) first = k; end
      if (div_out[1]) hi++;
    end
    n_tests++;
    if (strobes != 1 || first != 8 || hi != 5) begin
      n_fail++;
      $display("FAIL enable_first: strobes=%0d first=%0d div_high=%0d need 1/8/5", strobes, first, hi);
    end
    ch_en = 5'b11101;
    tick();
    n_tests++;
    if (ce_out[1] !== 1'b0 || div_out[1] !== 1'b0) begin
      n_fail++; $display("FAIL disable_low: ce=%b div=%b need 0/0", ce_out[1], div_out[1]);
    end
    ch_en = 5'h1F;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ce_out[1] && first == 0) first = k;
    end
    n_tests++;
    if (first != 8) begin n_fail++; $display("FAIL reenable_first: got %0d need 8", first); end
    cfg_send(1, 1);
    wait_ready("div1_apply", 20);
    ok = 1;
    for (int k = 0; k < 5; k++) begin
      if (ce_out[1] !== 1'b1 || div_out[1] !== 1'b1) ok = 0;
      tick();
    end
    n_tests++;
    if (ok != 1) begin n_fail++; $display("FAIL div1_held: ce=%b div=%b need 1/1", ce_out[1], div_out[1]); end
  endtask

  task automatic check_aligned(input string name, input int d0, input int d1,
                               input int d2, input int d3, input int nticks);
    int dv[4];
    int errs[4];
    int bad[4];
    logic exp_ce;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    for (int i = 0; i < 4; i++) begin errs[i] = 0; bad[i] = -1; end
    for (int j = 1; j <= nticks; j++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        exp_ce = ((j % dv[i]) == 0);
        if (ce_out[i] !== exp_ce) begin
          errs[i]++;
          if (bad[i] < 0) bad[i] = j;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (errs[i] != 0) begin
        n_fail++;
        $display("FAIL %s ch%0d: %0d wrong strobes, first at cycle %0d after sync, need 0", name, i, errs[i], bad[i]);
      end
    end
  endtask

  task automatic test_sync();
    ch_en = 5'b10000;
    tick();
    cfg_send(0, 3); wait_ready("sync_cfg0", 4);
    cfg_send(1, 5); wait_ready("sync_cfg1", 4);
    cfg_send(2, 7); wait_ready("sync_cfg2", 4);
    cfg_send(3, 9); wait_ready("sync_cfg3", 4);
    ch_en = 5'b10001; tick();
    ch_en = 5'b10011; tick();
    ch_en = 5'b10111; tick(); tick();
    ch_en = 5'b11111;
    repeat (20) tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check_aligned("sync_align", 3, 5, 7, 9, 46);
    cfg_send(3, 4);
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL sync_pending: ready=%b need 0", cfg_ready); end
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    n_tests++;
    if (ce_out[1:0] !== 2'b01) begin
      n_fail++; $display("FAIL sync_on_tc: ce[1:0]=%b need 01", ce_out[1:0]);
    end
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sync_apply_ready: got %b need 1", cfg_ready); end
    check_aligned("sync_realign", 3, 5, 7, 4, 40);
  endtask

  task automatic test_reset_mid();
    int early;
    logic [NCH-1:0] ce161;
    logic rdy1;
    cfg_send(4, 50);
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: ready=%b need 0", cfg_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (ce_out !== 5'h00 || div_out !== 5'h00 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ce=%h div=%h ready=%b err=%b need 00/00/0/0", ce_out, div_out, cfg_ready, cfg_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    early = 0; rdy1 = 1'b0; ce161 = '0;
    for (int k = 1; k <= 161; k++) begin
      tick();
      if (k == 1) rdy1 = cfg_ready;
      if (k < 161 && ce_out != '0) early++;
      if (k == 161) ce161 = ce_out;
    end
    n_tests++;
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b need 1", rdy1); end
    n_tests++;
    if (early != 0 || ce161 !== 5'h1F) begin
      n_fail++;
      $display("FAIL midrst_default: early strobes=%0d ce at 161=%h need 0/1f", early, ce161);
    end
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_no_pending: ready=%b need 1", cfg_ready); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_ratio_change();
    test_cfg_err();
    test_enable();
    test_sync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
